// File: rtl/coef_pkg.sv
// +----------------------------------------------------------------------+
// | coef_pkg                                                              |
// | Shared coefficient format, band codes and sequencer state encoding.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package coef_pkg;

  localparam int COEF_WIDTH = 22;
  localparam int COEF_FRAC  = 14;

  localparam logic [1:0] BAND_OFF = 2'd0;
  localparam logic [1:0] BAND_LO  = 2'd1;
  localparam logic [1:0] BAND_MID = 2'd2;
  localparam logic [1:0] BAND_HI  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TICK = 2'd1,
    ST_FLUSH     = 2'd2,
    ST_LOAD      = 2'd3
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/coef_band_sequencer.sv
// +----------------------------------------------------------------------+
// | coef_band_sequencer                                                   |
// | Applies band-select changes on sample boundaries, flushing the IIR    |
// | state and capturing the newly selected coefficient.                   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module coef_band_sequencer
  import coef_pkg::*;
#(
  parameter int WIDTH        = COEF_WIDTH,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       band_req,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             sample_tick,
  input  logic [WIDTH-1:0] coef_in,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] coef_q,
  output logic             filt_clear,
  output logic             filt_hold,
  output logic             done,
  output logic             tick_missed
);

  localparam logic [3:0] c_flush_last = 4'(FLUSH_CYCLES - 1);

  seq_state_t       r_state, w_state_next;
  logic [1:0]       r_sel, w_sel_next;
  logic [1:0]       r_pending, w_pending_next;
  logic [WIDTH-1:0] r_coef, w_coef_next;
  logic [3:0]       r_cnt, w_cnt_next;
  logic             r_clear, w_clear_next;
  logic             r_hold, w_hold_next;
  logic             r_done, w_done_next;
  logic             r_missed, w_missed_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_sel     <= BAND_OFF;
      r_pending <= BAND_OFF;
      r_coef    <= '0;
      r_cnt     <= 4'd0;
      r_clear   <= 1'b0;
      r_hold    <= 1'b0;
      r_done    <= 1'b0;
      r_missed  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_sel     <= w_sel_next;
      r_pending <= w_pending_next;
      r_coef    <= w_coef_next;
      r_cnt     <= w_cnt_next;
      r_clear   <= w_clear_next;
      r_hold    <= w_hold_next;
      r_done    <= w_done_next;
      r_missed  <= w_missed_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_sel_next     = r_sel;
    w_pending_next = r_pending;
    w_coef_next    = r_coef;
    w_cnt_next     = r_cnt;
    w_clear_next   = r_clear;
    w_hold_next    = r_hold;
    w_done_next    = 1'b0;
    // Ticks that land while the datapath is frozen are dropped, only flagged.
    w_missed_next  = sample_tick & r_hold;

    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (band_req == r_sel) begin
            w_done_next = 1'b1;
          end else begin
            w_pending_next = band_req;
            w_state_next   = ST_WAIT_TICK;
          end
        end
      end
      ST_WAIT_TICK: begin
        if (sample_tick) begin
          w_sel_next   = r_pending;
          w_hold_next  = 1'b1;
          w_clear_next = 1'b1;
          w_cnt_next   = c_flush_last;
          w_state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (r_cnt == 4'd0) begin
          w_clear_next = 1'b0;
          w_state_next = ST_LOAD;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      ST_LOAD: begin
        // The mux has settled on the new sel for the whole flush window.
        w_coef_next  = coef_in;
        w_hold_next  = 1'b0;
        w_done_next  = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign req_ready   = (r_state == ST_IDLE) & rst_n;
  assign sel         = r_sel;
  assign coef_q      = r_coef;
  assign filt_clear  = r_clear;
  assign filt_hold   = r_hold;
  assign done        = r_done;
  assign tick_missed = r_missed;

endmodule

`default_nettype wire

// File: tb/tb_coef_band_sequencer.sv
// +----------------------------------------------------------------------+
// | tb_coef_band_sequencer                                                |
// | Self-checking bench: timeline reference model plus directed checks.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_coef_band_sequencer;
  import coef_pkg::*;

  localparam int W = 22;
  localparam int F = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [1:0]   band_req = 2'd0;
  logic         req_valid = 1'b0;
  logic         sample_tick = 1'b0;
  logic [W-1:0] coef_in;
  logic         req_ready;
  logic [1:0]   sel;
  logic [W-1:0] coef_q;
  logic         filt_clear, filt_hold, done, tick_missed;

  always #5 clk = ~clk;

  // Low-pass b1 coefficient mux driven by sel.
  function automatic logic [W-1:0] lp_b1(input logic [1:0] s);
    case (s)
      2'd1:    return 22'h000007;
      2'd2:    return 22'h000AA5;
      2'd3:    return 22'h006810;
      default: return 22'h000000;
    endcase
  endfunction

  assign coef_in = lp_b1(sel);

  coef_band_sequencer #(.WIDTH(W), .FLUSH_CYCLES(F)) dut (
    .clk(clk), .rst_n(rst_n), .band_req(band_req), .req_valid(req_valid),
    .req_ready(req_ready), .sample_tick(sample_tick), .coef_in(coef_in),
    .sel(sel), .coef_q(coef_q), .filt_clear(filt_clear), .filt_hold(filt_hold),
    .done(done), .tick_missed(tick_missed)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference model: a change is described by the cycle t0 in which the
  // flush window opens; everything else is an offset from t0.
  logic [1:0]   m_sel = 2'd0, m_pending = 2'd0;
  logic [W-1:0] m_coef = '0;
  logic         m_waiting = 1'b0, m_done = 1'b0, m_missed = 1'b0, m_acc = 1'b0;
  int           m_t0 = -1;

  function automatic bit m_in_flush();
    return (m_t0 >= 0) && ((cyc - m_t0) <= F);
  endfunction

  function automatic bit m_ready();
    return rst_n && !m_waiting && (m_t0 < 0);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sel <= 2'd0; m_pending <= 2'd0; m_coef <= '0; m_waiting <= 1'b0;
      m_done <= 1'b0; m_missed <= 1'b0; m_acc <= 1'b0; m_t0 <= -1;
    end else begin
      m_done   <= 1'b0;
      m_missed <= sample_tick && m_in_flush();
      m_acc    <= req_valid && m_ready();
      if (m_in_flush() && ((cyc - m_t0) == F)) begin
        m_coef <= lp_b1(m_sel);
        m_done <= 1'b1;
        m_t0   <= -1;
      end else if (m_waiting) begin
        if (sample_tick) begin
          m_sel     <= m_pending;
          m_waiting <= 1'b0;
          m_t0      <= cyc + 1;
        end
      end else if ((m_t0 < 0) && req_valid) begin
        if (band_req == m_sel) m_done <= 1'b1;
        else begin
          m_pending <= band_req;
          m_waiting <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("sel", 32'(sel), 32'(m_sel));
    chk("coef_q", 32'(coef_q), 32'(m_coef));
    chk("filt_clear", 32'(filt_clear), 32'((m_t0 >= 0) && ((cyc - m_t0) < F)));
    chk("filt_hold", 32'(filt_hold), 32'(m_in_flush()));
    chk("done", 32'(done), 32'(m_done));
    chk("tick_missed", 32'(tick_missed), 32'(m_missed));
    chk("req_ready", 32'(req_ready), 32'(m_ready()));
  end

  int clear_cnt, hold_cnt, done_cnt, missed_cnt, first_done, first_sel, c0;
  logic [1:0] tgt;

  task automatic reset_tally(input logic [1:0] t);
    clear_cnt = 0; hold_cnt = 0; done_cnt = 0; missed_cnt = 0;
    first_done = -1; first_sel = -1; tgt = t;
  endtask

  task automatic tally();
    if (filt_clear) clear_cnt++;
    if (filt_hold) hold_cnt++;
    if (tick_missed) missed_cnt++;
    if (done) begin
      done_cnt++;
      if (first_done < 0) first_done = cyc;
    end
    if (sel == tgt && first_sel < 0) first_sel = cyc;
  endtask

  task automatic drive(input logic v, input logic [1:0] b, input logic t);
    @(negedge clk);
    #1;
    req_valid = v; band_req = b; sample_tick = t;
  endtask

  task automatic observe(input int n, input logic v, input logic [1:0] b);
    for (int i = 0; i < n; i++) begin
      drive(v, b, 1'b0);
      tally();
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    chk("ready_in_reset", 32'(req_ready), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    drive(1'b0, 2'd0, 1'b0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_coef", 32'(coef_q), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_pulses", 32'({filt_clear, filt_hold, done, tick_missed}), 32'd0);

    // Change to low band, tick five cycles after the accept.
    reset_tally(2'd1);
    drive(1'b1, 2'd1, 1'b0); c0 = cyc; tally();
    observe(4, 1'b0, 2'd1);
    drive(1'b0, 2'd1, 1'b1); tally();
    observe(20, 1'b0, 2'd1);
    chk("lo_latency", 32'(first_done - c0), 32'd11);
    chk("lo_clear_cycles", 32'(clear_cnt), 32'd4);
    chk("lo_done_count", 32'(done_cnt), 32'd1);
    chk("lo_sel_cycle", 32'(first_sel - c0), 32'd6);
    chk("lo_coef", 32'(coef_q), 32'h000007);

    // Move to mid band, then request mid again.
    drive(1'b1, 2'd2, 1'b0); observe(2, 1'b0, 2'd2);
    drive(1'b0, 2'd2, 1'b1); observe(12, 1'b0, 2'd2);
    chk("mid_coef", 32'(coef_q), 32'h000AA5);
    reset_tally(2'd2);
    drive(1'b1, 2'd2, 1'b0); c0 = cyc; tally();
    observe(5, 1'b0, 2'd2);
    chk("same_clear", 32'(clear_cnt), 32'd0);
    chk("same_hold", 32'(hold_cnt), 32'd0);
    chk("same_done_count", 32'(done_cnt), 32'd1);
    chk("same_done_cycle", 32'(first_done - c0), 32'd1);
    chk("same_coef", 32'(coef_q), 32'h000AA5);

    // High band with a competing request and a stray tick during the flush.
    drive(1'b1, 2'd3, 1'b0); observe(1, 1'b0, 2'd3);
    drive(1'b0, 2'd3, 1'b1);
    reset_tally(2'd3);
    drive(1'b1, 2'd1, 1'b0); tally();
    chk("bp_ready_flush", 32'(req_ready), 32'd0);
    drive(1'b1, 2'd1, 1'b1); tally();
    observe(12, 1'b1, 2'd1);
    chk("bp_missed", 32'(missed_cnt), 32'd1);
    chk("bp_done", 32'(done_cnt), 32'd1);
    chk("hi_coef", 32'(coef_q), 32'h006810);
    drive(1'b0, 2'd1, 1'b0);
    chk("bp_accepted_waiting", 32'(req_ready), 32'd0);
    drive(1'b0, 2'd1, 1'b1); observe(12, 1'b0, 2'd1);
    chk("bp_lo_sel", 32'(sel), 32'd1);
    chk("bp_lo_coef", 32'(coef_q), 32'h000007);

    // Accept and tick in the same cycle: that tick must not start the change.
    drive(1'b1, 2'd2, 1'b1);
    observe(5, 1'b0, 2'd2);
    chk("simul_sel_held", 32'(sel), 32'd1);
    drive(1'b0, 2'd2, 1'b1); observe(12, 1'b0, 2'd2);
    chk("simul_sel_new", 32'(sel), 32'd2);
    chk("simul_coef", 32'(coef_q), 32'h000AA5);

    // Reset during the second flush cycle.
    drive(1'b1, 2'd3, 1'b0); observe(1, 1'b0, 2'd3);
    drive(1'b0, 2'd3, 1'b1);
    drive(1'b0, 2'd3, 1'b0);
    @(negedge clk); #2;
    chk("mid_flush_clear_before", 32'(filt_clear), 32'd1);
    rst_n = 1'b0; #1;
    chk("async_clear", 32'(filt_clear), 32'd0);
    chk("async_hold", 32'(filt_hold), 32'd0);
    chk("async_sel", 32'(sel), 32'd0);
    chk("async_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    reset_tally(2'd3);
    observe(15, 1'b0, 2'd0);
    chk("post_rst_done", 32'(done_cnt), 32'd0);
    chk("post_rst_hold", 32'(hold_cnt), 32'd0);

    // Random traffic; the requester holds its band until accepted.
    for (int i = 0; i < 500; i++) begin
      logic v;
      logic [1:0] b;
      if (req_valid && !m_acc) begin
        v = 1'b1; b = band_req;
      end else begin
        v = ($urandom_range(0, 3) == 0);
        b = 2'($urandom_range(0, 3));
      end
      drive(v, b, $urandom_range(0, 4) == 0);
    end
    drive(1'b0, 2'd0, 1'b0);
    @(negedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule

`default_nettype wire
